// File: rtl/imem_boot_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_boot_ctrl_pkg
//   Shared definitions for the instruction-memory boot controller: default
//   geometry of the instruction memory, the controller state encoding and a
//   helper that decides whether a requested program length can be loaded.
//   No ports (package).
// ----------------------------------------------------------------------------
package imem_boot_ctrl_pkg;

    // Default instruction-memory geometry
    localparam int unsigned DefWidth = 32;    // instruction word width
    localparam int unsigned DefDepth = 1024;  // words
    localparam int unsigned DefAw    = 10;    // log2(DefDepth)

    // Controller states; encoding is fixed so it can be observed in debug dumps
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StRun   = 2'd3
    } boot_state_e;

    // A load must write at least one word and must fit in the memory
    function automatic logic len_is_legal(input int unsigned len,
                                          input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_boot_ctrl.sv
// ----------------------------------------------------------------------------
// imem_boot_ctrl
//   Boot loader controller for the instruction memory. A start request with a
//   legal word count streams that many words from a valid/ready source into
//   consecutive instruction-memory addresses starting at 0, holding the core
//   in reset until the final write has landed. The fetch read path of the
//   memory is outside this block.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to begin a program load
//   load_len   in   word count, sampled when start is accepted (AW+1 bits)
//   s_valid    in   loader stream word valid
//   s_data     in   loader stream word
//   s_ready    out  high only while loading; transfer = s_valid && s_ready
//   mem_we     out  registered instruction-memory write enable
//   mem_waddr  out  registered instruction-memory word address
//   mem_wdata  out  registered instruction-memory write data
//   core_rst   out  holds the core in reset whenever not running
//   busy       out  high while loading or flushing the final write
//   done       out  one-cycle pulse on the first cycle of RUN
//   err        out  sticky flag for a start with an illegal length
// ----------------------------------------------------------------------------
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      load_len,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    boot_state_e state_q, state_d;

    logic [AW-1:0]    cnt_q, cnt_d;     // address of the next word to write
    logic [AW:0]      len_q, len_d;     // word count latched at start
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic             mem_we_q;
    logic [AW-1:0]    mem_waddr_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic             len_ok;
    logic             can_start;
    logic             start_ok;
    logic             start_bad;
    logic             xfer;
    logic             last_xfer;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // Starts are only honoured when idle or running; during a load they are
    // dropped without touching err.
    assign len_ok    = len_is_legal(32'(load_len), DEPTH);
    assign can_start = (state_q == StIdle) || (state_q == StRun);
    assign start_ok  = can_start && start && len_ok;
    assign start_bad = can_start && start && !len_ok;

    assign xfer      = s_valid && (state_q == StLoad);
    assign last_xfer = xfer && ({1'b0, cnt_q} == (len_q - (AW+1)'(1)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle,
            StRun: begin
                if (start_ok) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (last_xfer) begin
                    state_d = StFlush;
                end
            end
            // The final word's write is in flight; it lands this cycle
            StFlush: state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        s_ready  = 1'b0;
        busy     = 1'b0;
        core_rst = 1'b1;
        case (state_q)
            StLoad: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            StFlush: busy     = 1'b1;
            StRun:   core_rst = 1'b0;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load bookkeeping: counter, latched length, status flags
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        err_d  = err_q;
        // FLUSH always moves to RUN, so this marks the first RUN cycle
        done_d = (state_q == StFlush);

        if (start_ok) begin
            len_d = load_len;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (start_bad) begin
            err_d = 1'b1;
        end

        // Hold the counter on the last word so a full-depth load never wraps
        if (xfer && !last_xfer) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory write port: each transfer becomes a write one cycle later
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= xfer;
            if (xfer) begin
                mem_waddr_q <= cnt_q;
                mem_wdata_q <= s_data;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
